led_target_generator: RTL and testbench

- Drives the 18 game LEDs for the LED/switch reaction game, one target LED per round, across a fixed number of rounds.
- Picks each target from a free-running LFSR, then ends the round on a hit (rising edge of the matching switch) or on timeout.
- Emits hit/miss pulses and round status to the scoring and display logic.
- Its `leds` output is the LED vector the score checker compares against the switches.

---
 rtl/led_game_pkg.sv | 29 ++
 rtl/lfsr16.sv | 24 ++
 rtl/led_target_generator.sv | 168 ++++++++++++++++
 tb/tb_led_target_generator.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/led_game_pkg.sv
// Shared types and constants for the LED/switch reaction game (target generator
// and score checker).
package led_game_pkg;

  localparam int unsigned NUM_LEDS_DEFAULT = 18;
  localparam int unsigned LED_IDX_W        = 5;
  localparam int unsigned LFSR_W           = 16;
  localparam logic [LFSR_W-1:0] LFSR_TAPS  = 16'hB400;

  typedef enum logic [2:0] {
    IDLE,
    PICK,
    SHOW,
    GAP,
    DONE
  } gen_state_t;

  // Reduce a raw 5-bit value into 0..n-1 by repeated subtraction (n >= 2 needs at most 15)
  function automatic logic [LED_IDX_W-1:0] fold_idx(input logic [LED_IDX_W-1:0] raw,
                                                    input int unsigned n);
    logic [LED_IDX_W-1:0] r;
    r = raw;
    for (int unsigned i = 0; i < 16; i++) begin
      if (32'(r) >= n) r = r - LED_IDX_W'(n);
    end
    return r;
  endfunction

endpackage

// File: rtl/lfsr16.sv
// Free-running 16-bit Galois LFSR; a zero seed is replaced by 1 so the
// register can never lock up.
module lfsr16
  import led_game_pkg::*;
#(
  parameter logic [LFSR_W-1:0] SEED = 16'hACE1
) (
  input  logic              clk,
  input  logic              reset,
  output logic [LFSR_W-1:0] o_state
);

  localparam logic [LFSR_W-1:0] SAFE_SEED = (SEED == '0) ? LFSR_W'(1) : SEED;

  logic [LFSR_W-1:0] r_lfsr;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_lfsr <= SAFE_SEED;
    else       r_lfsr <= (r_lfsr >> 1) ^ (r_lfsr[0] ? LFSR_TAPS : '0);
  end

  assign o_state = r_lfsr;

endmodule

// File: rtl/led_target_generator.sv
// Reaction-game target generator: LFSR-picked one-hot target per round, hit/miss
// detection and round sequencing. Optional input sync: LED_TARGET_GEN_SYNC_EN.
module led_target_generator
  import led_game_pkg::*;
#(
  parameter int unsigned       NUM_LEDS   = NUM_LEDS_DEFAULT,
  parameter int unsigned       SHOW_TICKS = 50_000_000,
  parameter int unsigned       GAP_TICKS  = 12_500_000,
  parameter int unsigned       NUM_ROUNDS = 10,
  parameter logic [LFSR_W-1:0] LFSR_SEED  = 16'hACE1
) (
  input  logic                                clk,
  input  logic                                reset,
  input  logic                                start,
  input  logic [NUM_LEDS-1:0]                 switches,
  output logic [NUM_LEDS-1:0]                 leds,
  output logic [LED_IDX_W-1:0]                target_idx,
  output logic                                hit,
  output logic                                miss,
  output logic [$clog2(NUM_ROUNDS+1)-1:0]     round_num,
  output logic                                busy,
  output logic                                done
);

  localparam int unsigned RND_W   = $clog2(NUM_ROUNDS + 1);
  localparam int unsigned TMR_MAX = (SHOW_TICKS > GAP_TICKS) ? SHOW_TICKS : GAP_TICKS;
  localparam int unsigned TMR_W   = $clog2(TMR_MAX);

  gen_state_t           r_state, w_state_nxt;
  logic [TMR_W-1:0]     r_timer, w_timer_nxt;
  logic [NUM_LEDS-1:0]  r_sw_prev, w_sw;
  logic [NUM_LEDS-1:0]  r_leds, w_leds_nxt;
  logic [LED_IDX_W-1:0] r_target_idx, w_idx_nxt, w_raw, w_pick_idx;
  logic [RND_W-1:0]     r_round, w_round_nxt, w_round_inc;
  logic                 r_hit, w_hit_nxt, r_miss, w_miss_nxt;
  logic                 r_busy, w_busy_nxt, r_done, w_done_nxt;
  logic [LFSR_W-1:0]    w_lfsr;
  logic                 w_lfsr_unused;
  logic [31:0]          w_sw_pad, w_prev_pad;
  logic                 w_edge;

  lfsr16 #(.SEED(LFSR_SEED)) u_lfsr (
    .clk     (clk),
    .reset   (reset),
    .o_state (w_lfsr)
  );

  assign w_lfsr_unused = ^w_lfsr[LFSR_W-1:LED_IDX_W];

`ifdef LED_TARGET_GEN_SYNC_EN
  logic [NUM_LEDS-1:0] r_sync1, r_sync2;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
    end else begin
      r_sync1 <= switches;
      r_sync2 <= r_sync1;
    end
  end

  assign w_sw = r_sync2;
`else
  assign w_sw = switches;
`endif

  // Rising edge on the current target switch only
  assign w_sw_pad   = 32'(w_sw);
  assign w_prev_pad = 32'(r_sw_prev);
  assign w_edge     = w_sw_pad[r_target_idx] & ~w_prev_pad[r_target_idx];

  // Avoid repeating the previous target within a game
  assign w_raw = fold_idx(w_lfsr[LED_IDX_W-1:0], NUM_LEDS);

  always_comb begin
    w_pick_idx = w_raw;
    if (w_raw == r_target_idx && r_round != '0)
      w_pick_idx = (w_raw == LED_IDX_W'(NUM_LEDS - 1)) ? '0 : w_raw + LED_IDX_W'(1);
  end

  assign w_round_inc = r_round + RND_W'(1);

  always_comb begin
    w_state_nxt = r_state;
    w_timer_nxt = r_timer;
    w_idx_nxt   = r_target_idx;
    w_leds_nxt  = '0;
    w_hit_nxt   = 1'b0;
    w_miss_nxt  = 1'b0;
    w_round_nxt = r_round;
    case (r_state)
      IDLE, DONE: begin
        if (start) begin
          w_state_nxt = PICK;
          w_round_nxt = '0;
        end
      end
      PICK: begin
        w_idx_nxt   = w_pick_idx;
        w_leds_nxt  = NUM_LEDS'(32'd1 << w_pick_idx);
        w_timer_nxt = '0;
        w_state_nxt = SHOW;
      end
      SHOW: begin
        if (w_edge) begin
          w_hit_nxt   = 1'b1;
          w_timer_nxt = '0;
          w_state_nxt = GAP;
        end else if (r_timer == TMR_W'(SHOW_TICKS - 1)) begin
          w_miss_nxt  = 1'b1;
          w_timer_nxt = '0;
          w_state_nxt = GAP;
        end else begin
          w_timer_nxt = r_timer + TMR_W'(1);
          w_leds_nxt  = r_leds;
        end
      end
      GAP: begin
        if (r_timer == TMR_W'(GAP_TICKS - 1)) begin
          w_timer_nxt = '0;
          w_round_nxt = w_round_inc;
          w_state_nxt = (w_round_inc == RND_W'(NUM_ROUNDS)) ? DONE : PICK;
        end else begin
          w_timer_nxt = r_timer + TMR_W'(1);
        end
      end
      default: w_state_nxt = IDLE;
    endcase
    w_busy_nxt = (w_state_nxt == PICK) || (w_state_nxt == SHOW) || (w_state_nxt == GAP);
    w_done_nxt = (w_state_nxt == DONE);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state      <= IDLE;
      r_timer      <= '0;
      r_sw_prev    <= '0;
      r_target_idx <= '0;
      r_leds       <= '0;
      r_hit        <= 1'b0;
      r_miss       <= 1'b0;
      r_round      <= '0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_timer      <= w_timer_nxt;
      r_sw_prev    <= w_sw;
      r_target_idx <= w_idx_nxt;
      r_leds       <= w_leds_nxt;
      r_hit        <= w_hit_nxt;
      r_miss       <= w_miss_nxt;
      r_round      <= w_round_nxt;
      r_busy       <= w_busy_nxt;
      r_done       <= w_done_nxt;
    end
  end

  assign leds       = r_leds;
  assign target_idx = r_target_idx;
  assign hit        = r_hit;
  assign miss       = r_miss;
  assign round_num  = r_round;
  assign busy       = r_busy;
  assign done       = r_done;

endmodule

// File: tb/tb_led_target_generator.sv
// Directed self-checking bench for led_target_generator with short show/gap
// timing and an independent LFSR reference for the expected targets.
module tb_led_target_generator;

  localparam int unsigned N      = 18;
  localparam int unsigned SHOW   = 8;
  localparam int unsigned GAP    = 2;
  localparam int unsigned ROUNDS = 3;
  localparam int unsigned J_SEEK = 3;
  localparam logic [15:0] SEED   = 16'hACE1;
  localparam int M_NONE = 0, M_HIT = 1, M_HELD = 2, M_TOGGLE = 3;

  logic         clk = 1'b0;
  logic         reset, start;
  logic [N-1:0] switches, leds;
  logic [4:0]   target_idx;
  logic         hit, miss, busy, done;
  logic [1:0]   round_num;

  int           checks = 0;
  int           errors = 0;
  logic [15:0]  m_lfsr;
  logic [4:0]   b_prev, g_last_e, first_tgt, e1;
  int           b_rnd;
  bit           gap_start, found;

  always #5 clk = ~clk;

  led_target_generator #(
    .NUM_LEDS   (N),
    .SHOW_TICKS (SHOW),
    .GAP_TICKS  (GAP),
    .NUM_ROUNDS (ROUNDS),
    .LFSR_SEED  (SEED)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .switches   (switches),
    .leds       (leds),
    .target_idx (target_idx),
    .hit        (hit),
    .miss       (miss),
    .round_num  (round_num),
    .busy       (busy),
    .done       (done)
  );

  function automatic logic [15:0] step(input logic [15:0] v);
    return v[0] ? ((v >> 1) ^ 16'hB400) : (v >> 1);
  endfunction

  function automatic logic [15:0] adv(input logic [15:0] v, input int n);
    logic [15:0] r;
    r = v;
    for (int i = 0; i < n; i++) r = step(r);
    return r;
  endfunction

  function automatic logic [4:0] exp_idx(input logic [15:0] v, input logic [4:0] prev,
                                         input int rnd);
    int r;
    r = int'(v[4:0]);
    if (r >= 18) r = r - 18;
    if (rnd != 0 && r == int'(prev)) r = (r == 17) ? 0 : r + 1;
    return 5'(r);
  endfunction

  // Reference LFSR, tracking the DUT's generator cycle for cycle
  always @(posedge clk or posedge reset) begin
    if (reset) m_lfsr <= SEED;
    else       m_lfsr <= step(m_lfsr);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Mid-cycle async reset, release on a negedge, then a fixed idle run
  task automatic reset_and_idle();
    start    = 1'b0;
    switches = '0;
    #2 reset = 1'b1;
    #1;
    chk("rst_leds",   32'(leds), 32'(0));
    chk("rst_tidx",   32'(target_idx), 32'(0));
    chk("rst_hit",    32'(hit), 32'(0));
    chk("rst_miss",   32'(miss), 32'(0));
    chk("rst_round",  32'(round_num), 32'(0));
    chk("rst_busy",   32'(busy), 32'(0));
    chk("rst_done",   32'(done), 32'(0));
    @(negedge clk);
    reset  = 1'b0;
    b_prev = '0;
    b_rnd  = 0;
    repeat (3) tick();
  endtask

  task automatic start_game();
    start = 1'b1;
    tick();
    start = 1'b0;
    b_rnd = 0;
    chk("round_clr", 32'(round_num), 32'(0));
    chk("done_clr",  32'(done), 32'(0));
  endtask

  // Entered in the PICK cycle; leaves in the cycle after the GAP exit
  task automatic run_round(input int mode, input int j);
    logic [4:0]   e;
    logic [N-1:0] oh;
    bit           hitted;
    chk("busy_pick", 32'(busy), 32'(1));
    chk("leds_pick", 32'(leds), 32'(0));
    e = exp_idx(m_lfsr, b_prev, b_rnd);
    if (mode == M_HELD) switches = '1;
    tick();
    oh = N'(1) << e;
    chk("target_idx", 32'(target_idx), 32'(e));
    chk("tgt_range",  32'(target_idx < 5'd18), 32'(1));
    hitted = 1'b0;
    for (int c = 0; c < int'(SHOW); c++) begin
      chk("leds_show", 32'(leds), 32'(oh));
      chk("hit_show",  32'(hit), 32'(0));
      chk("miss_show", 32'(miss), 32'(0));
      if (mode == M_HIT && c == j) switches[e] = 1'b1;
      if (mode == M_TOGGLE) switches = ~switches & ~oh;
      tick();
      if (mode == M_HIT && c == j) begin
        hitted = 1'b1;
        break;
      end
    end
    chk("hit_pulse",  32'(hit), 32'(hitted));
    chk("miss_pulse", 32'(miss), 32'(!hitted));
    chk("leds_gap0",  32'(leds), 32'(0));
    chk("busy_gap0",  32'(busy), 32'(1));
    switches = '0;
    if (gap_start) start = 1'b1;
    tick();
    start = 1'b0;
    chk("hit_gap1",   32'(hit), 32'(0));
    chk("miss_gap1",  32'(miss), 32'(0));
    chk("leds_gap1",  32'(leds), 32'(0));
    chk("busy_gap1",  32'(busy), 32'(1));
    chk("round_gap1", 32'(round_num), 32'(b_rnd));
    tick();
    b_rnd++;
    b_prev   = e;
    g_last_e = e;
    chk("round_num", 32'(round_num), 32'(b_rnd));
  endtask

  task automatic check_done();
    chk("done_set",   32'(done), 32'(1));
    chk("done_busy",  32'(busy), 32'(0));
    chk("done_leds",  32'(leds), 32'(0));
    chk("done_round", 32'(round_num), 32'(ROUNDS));
    tick();
    chk("done_hold",  32'(done), 32'(1));
    chk("round_hold", 32'(round_num), 32'(ROUNDS));
  endtask

  // Idle until starting now makes round 2 draw the same index as round 1
  task automatic seek(input bit want17, output bit ok);
    logic [4:0] i1, r2;
    ok = 1'b0;
    for (int w = 0; w < 20000 && !ok; w++) begin
      i1 = exp_idx(step(m_lfsr), 5'd0, 0);
      r2 = exp_idx(adv(m_lfsr, 3 + int'(J_SEEK) + int'(GAP)), 5'd0, 0);
      if (r2 == i1 && ((i1 == 5'd17) == want17)) ok = 1'b1;
      else tick();
    end
    chk("seek_found", 32'(ok), 32'(1));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset     = 1'b0;
    start     = 1'b0;
    switches  = '0;
    b_prev    = '0;
    b_rnd     = 0;
    gap_start = 1'b0;

    reset_and_idle();
    chk("idle_busy", 32'(busy), 32'(0));
    chk("idle_done", 32'(done), 32'(0));
    chk("idle_leds", 32'(leds), 32'(0));

    // Game 1: no switch activity, every round times out
    start_game();
    run_round(M_NONE, 0);
    first_tgt = g_last_e;
    run_round(M_NONE, 0);
    run_round(M_NONE, 0);
    check_done();

    // Game 2: hit at SHOW cycle 3, pre-held target, non-target toggling
    repeat (2) tick();
    start_game();
    run_round(M_HIT, 3);
    run_round(M_HELD, 0);
    run_round(M_TOGGLE, 0);
    check_done();

    // Game 3: repeated draw bumps to prev+1; last round hits on the final tick
    seek(1'b0, found);
    start_game();
    run_round(M_HIT, int'(J_SEEK));
    e1 = g_last_e;
    run_round(M_NONE, 0);
    chk("bump_idx", 32'(target_idx), 32'(e1 + 5'd1));
    run_round(M_HIT, int'(SHOW) - 1);
    check_done();

    // Game 4: repeated draw of 17 wraps to 0
    seek(1'b1, found);
    start_game();
    run_round(M_HIT, int'(J_SEEK));
    chk("prev_17", 32'(g_last_e), 32'(17));
    run_round(M_NONE, 0);
    chk("wrap_idx", 32'(target_idx), 32'(0));
    run_round(M_NONE, 0);
    check_done();

    // Game 5: start in GAP ignored, then reset mid-SHOW and replay
    start_game();
    gap_start = 1'b1;
    run_round(M_NONE, 0);
    gap_start = 1'b0;
    repeat (3) tick();
    chk("pre_rst_busy",  32'(busy), 32'(1));
    chk("pre_rst_round", 32'(round_num), 32'(1));
    reset_and_idle();
    start_game();
    run_round(M_NONE, 0);
    chk("replay_tgt", 32'(target_idx), 32'(first_tgt));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
